jtag_tdo_word_packer: RTL and testbench
=======================================

JTAG_TDO_WORD_PACKER -- requirements
Module: jtag_tdo_word_packer

Interface
REQ-001 Parameter DATA_WIDTH, 32, packed word width.
REQ-002 Parameter DEPTH_WIDTH, 6, log2 of buffer depth in words (64 words).
REQ-003 Parameter ALMOST_FULL_NUM, 63, level at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_NUM, 4, level at or below which almost_empty asserts.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 tb_rst  input  1  reset, asynchronous, active-high.
REQ-007 bit_in  input  1  serial TDO bit.
REQ-008 bit_valid  input  1  bit_in is sampled this edge.
REQ-009 flush  input  1  push the partial word, zero-padded.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_data  output  DATA_WIDTH  registered read word.
REQ-012 rd_empty  output  1  level == 0.
REQ-013 wr_full  output  1  level == 2**DEPTH_WIDTH.
REQ-014 almost_full  output  1  level >= ALMOST_FULL_NUM.
REQ-015 almost_empty  output  1  level <= ALMOST_EMPTY_NUM.
REQ-016 rd_water_level  output  DEPTH_WIDTH+1  words stored, 0..64.
REQ-017 bit_cnt  output  5  bits held in the partial word, 0..31.
REQ-018 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-019 Packing SHALL be LSB-first: the first valid bit of a word lands in bit 0, the 32nd in bit 31.
REQ-020 On an edge with bit_valid=1 and bit_cnt<31: store the bit at position bit_cnt; bit_cnt increments.
REQ-021 On an edge with bit_valid=1 and bit_cnt==31: the completed word (current bit in bit 31) is written to the buffer on that same edge; bit_cnt wraps to 0; the partial register clears.
REQ-022 flush with bit_cnt>0 and no word completing: push the partial word with upper bits 0 (including bit_in at position bit_cnt if bit_valid=1); bit_cnt goes to 0.
REQ-023 flush coinciding with a word completion SHALL produce exactly one push, the completed word.
REQ-024 flush with bit_cnt==0 and bit_valid=0 SHALL do nothing.
REQ-025 A push SHALL be accepted if level < 64, or if a read is accepted on the same edge.
REQ-026 A rejected push SHALL discard the word, set overflow, and leave the buffer and level unchanged.
REQ-027 A read SHALL be accepted when rd_en=1 and level > 0 (sampled before the edge).
REQ-028 The accepted word SHALL appear on rd_data after that edge (1-cycle latency) and hold until the next accepted read.
REQ-029 rd_en on an empty buffer SHALL be ignored; rd_data holds its value.
REQ-030 Accepted push with accepted read: level unchanged. Push only: level +1. Read only: level -1.
REQ-031 Word order SHALL be strict FIFO. Pointers are DEPTH_WIDTH+1 bits and wrap modulo 128.
REQ-032 Status flags SHALL be derived from the registered level and valid in the cycle after the edge that changed it.
REQ-033 overflow SHALL clear only on reset.

Reset
REQ-034 tb_rst=1 SHALL immediately clear:
- rd_data, rd_water_level, bit_cnt, overflow and the partial word to 0;
- pointers to 0.
It SHALL also set rd_empty=1, almost_empty=1, wr_full=0 and almost_full=0.
REQ-035 Reset mid-word or mid-read SHALL discard all buffered and partial data; the first bit after release lands in bit 0.
REQ-036 Buffer RAM contents need not be cleared; reads of stale data are impossible because level==0.

Verification
REQ-037 Fill: send 2048 bits forming words 0xFFFFFFFF-k (k=0..63), LSB-first, then hold rd_en for 64 edges.
- After filling: level 64, wr_full=1, almost_full=1.
- rd_data SHALL sequence 0xFFFFFFFF down to 0xFFFFFFC0.
- After draining: rd_empty=1, almost_empty=1.
REQ-038 Overflow: fill 64 words, send 32 more bits of 0x12345678.
- overflow=1, level stays 64.
- Readback SHALL contain only the original 64 words.
REQ-039 Flush: send bits 1,0,1,1,0 then pulse flush.
- One word 0x0000000D, level 1, bit_cnt 0.
- A second flush pushes nothing.
REQ-040 Simultaneous access at full: complete a word with rd_en=1 on the same edge.
- Level stays 64, overflow stays 0.
- The oldest word is read, and the new word is last in readback.
REQ-041 Reset mid-word: after 17 bits, pulse tb_rst, then send 32 bits of 0xA5A5A5A5.
- Exactly one word, 0xA5A5A5A5, is stored, and bit_cnt=0.
REQ-042 Empty read: with level 0, pulse rd_en for 3 cycles.
- rd_data unchanged, level 0, no flag change.

Source files
------------

// File: rtl/jtag_tdo_word_packer.sv
// ---------------------------------------------------------------------------
// jtag_tdo_word_packer
//
// Collects serial JTAG TDO bits LSB-first into DATA_WIDTH-bit words. Each
// completed (or flushed, zero-padded) word goes into a 2**DEPTH_WIDTH-word
// FIFO that is drained through a registered read port.
//
// Ports
//   clk             rising-edge clock
//   tb_rst          asynchronous, active-high reset
//   bit_in          serial TDO bit
//   bit_valid       bit_in is sampled on this edge
//   flush           push the partial word, upper bits zero
//   rd_en           read request; ignored while the buffer is empty
//   rd_data         last word read (1-cycle latency, held between reads)
//   rd_empty        level == 0
//   wr_full         level == 2**DEPTH_WIDTH
//   almost_full     level >= ALMOST_FULL_NUM
//   almost_empty    level <= ALMOST_EMPTY_NUM
//   rd_water_level  words stored
//   bit_cnt         bits held in the partial word
//   overflow        sticky: a completed word was dropped because the buffer was full
// ---------------------------------------------------------------------------
module jtag_tdo_word_packer #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 6,
    parameter int ALMOST_FULL_NUM  = 63,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  flush,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_WIDTH:0]  rd_water_level,
    output logic [4:0]            bit_cnt,
    output logic                  overflow
);

    localparam int                 DEPTH    = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_LVL = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0] AF_LVL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AE_LVL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
    localparam logic [4:0]           LAST_BIT = 5'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] partial_q, partial_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [DEPTH_WIDTH:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] cur_word;
    logic [DEPTH_WIDTH:0]  level;
    logic                  word_done;
    logic                  has_bits;
    logic                  push;
    logic                  push_ok;
    logic                  rd_ok;

    // Pointers carry one extra bit so full (difference == DEPTH) and empty
    // (difference == 0) are distinguishable; the difference is the level.
    assign level = wr_ptr_q - rd_ptr_q;

    // Partial word with this edge's bit merged in; this is what gets pushed
    // both on completion and on flush.
    always_comb begin
        cur_word = partial_q;
        if (bit_valid) begin
            cur_word[bit_cnt_q] = bit_in;
        end
    end

    assign word_done = bit_valid && (bit_cnt_q == LAST_BIT);
    assign has_bits  = bit_valid || (bit_cnt_q != 5'd0);
    // A flush on a completing edge folds into the single completion push.
    assign push      = word_done || (flush && has_bits);
    assign rd_ok     = rd_en && (level != '0);
    // A same-edge read frees a slot, so a full buffer can still accept.
    assign push_ok   = push && ((level != FULL_LVL) || rd_ok);

    always_comb begin
        partial_d  = partial_q;
        bit_cnt_d  = bit_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;

        if (push) begin
            partial_d = '0;
            bit_cnt_d = 5'd0;
        end else if (bit_valid) begin
            partial_d = cur_word;
            bit_cnt_d = bit_cnt_q + 5'd1;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (push) begin
            overflow_d = 1'b1;
        end

        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            partial_q  <= '0;
            bit_cnt_q  <= 5'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            partial_q  <= partial_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            // When full with a simultaneous push, both pointers address the
            // same slot; the read sees the old (oldest) word before the write.
            if (rd_ok) begin
                rd_data_q <= mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
            end
        end
    end

    // Storage is never reset; level == 0 after reset prevents stale reads.
    always_ff @(posedge clk) begin
        if (push_ok && !tb_rst) begin
            mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= cur_word;
        end
    end

    assign rd_data        = rd_data_q;
    assign rd_water_level = level;
    assign bit_cnt        = bit_cnt_q;
    assign overflow       = overflow_q;
    assign rd_empty       = (level == '0);
    assign wr_full        = (level == FULL_LVL);
    assign almost_full    = (level >= AF_LVL);
    assign almost_empty   = (level <= AE_LVL);

endmodule

// File: tb/tb_jtag_tdo_word_packer.sv
module tb_jtag_tdo_word_packer;

    logic        clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_empty, wr_full, almost_full, almost_empty;
    logic [6:0]  rd_water_level;
    logic [4:0]  bit_cnt;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of words plus the bits collected so far.
    logic [31:0] m_q[$];
    logic [31:0] m_part;
    int          m_cnt;
    logic [31:0] m_rd;
    logic        m_ovf;

    jtag_tdo_word_packer dut (
        .clk            (clk),
        .tb_rst         (tb_rst),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .flush          (flush),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .wr_full        (wr_full),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .rd_water_level (rd_water_level),
        .bit_cnt        (bit_cnt),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_part = '0;
        m_cnt  = 0;
        m_rd   = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        int lvl;
        lvl = m_q.size();
        check({ctx, ".rd_data"},   rd_data, m_rd);
        check({ctx, ".level"},     32'(rd_water_level), 32'(lvl));
        check({ctx, ".bit_cnt"},   32'(bit_cnt), 32'(m_cnt));
        check({ctx, ".overflow"},  32'(overflow), 32'(m_ovf));
        check({ctx, ".empty"},     32'(rd_empty), 32'(lvl == 0));
        check({ctx, ".full"},      32'(wr_full), 32'(lvl == 64));
        check({ctx, ".afull"},     32'(almost_full), 32'(lvl >= 63));
        check({ctx, ".aempty"},    32'(almost_empty), 32'(lvl <= 4));
    endtask

    // One clock edge with the given inputs; model advances, then compare.
    task automatic step(input logic bv, input logic bi, input logic fl, input logic re);
        logic have_word;
        logic [31:0] word;
        bit_valid = bv;
        bit_in    = bi;
        flush     = fl;
        rd_en     = re;
        @(posedge clk);
        have_word = 1'b0;
        word      = '0;
        if (bv) begin
            m_part[m_cnt] = bi;
            m_cnt++;
        end
        if (m_cnt == 32 || (fl && m_cnt > 0)) begin
            have_word = 1'b1;
            word      = m_part;
            m_part    = '0;
            m_cnt     = 0;
        end
        if (re && m_q.size() > 0) m_rd = m_q.pop_front();
        if (have_word) begin
            if (m_q.size() < 64) m_q.push_back(word);
            else m_ovf = 1'b1;
        end
        #1;
        check_all("step");
    endtask

    task automatic send_word(input logic [31:0] w, input logic re_last);
        for (int i = 0; i < 32; i++) step(1'b1, w[i], 1'b0, (i == 31) ? re_last : 1'b0);
    endtask

    task automatic do_reset();
        #2;
        tb_rst    = 1'b1;
        bit_valid = 1'b0;
        flush     = 1'b0;
        rd_en     = 1'b0;
        model_clear();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        tb_rst = 1'b0;
        check_all("rst_rel");
    endtask

    initial begin
        logic [31:0] held;
        model_clear();
        #1;
        check_all("rst_init");
        @(posedge clk);
        #1;
        tb_rst = 1'b0;

        // Fill with 0xFFFFFFFF-k, then drain.
        for (int k = 0; k < 64; k++) send_word(32'hFFFF_FFFF - 32'(k), 1'b0);
        check("fill.level", 32'(rd_water_level), 32'd64);
        check("fill.full", 32'(wr_full), 32'd1);
        check("fill.afull", 32'(almost_full), 32'd1);
        for (int k = 0; k < 64; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("fill.rd_seq", rd_data, 32'hFFFF_FFFF - 32'(k));
        end
        check("drain.empty", 32'(rd_empty), 32'd1);
        check("drain.aempty", 32'(almost_empty), 32'd1);

        // Overflow: a 65th word is dropped.
        do_reset();
        for (int k = 0; k < 64; k++) send_word(32'(k * 32'h0101_0101 + 7), 1'b0);
        send_word(32'h1234_5678, 1'b0);
        check("ovf.flag", 32'(overflow), 32'd1);
        check("ovf.level", 32'(rd_water_level), 32'd64);
        for (int k = 0; k < 64; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("ovf.rd", rd_data, 32'(k * 32'h0101_0101 + 7));
        end
        check("ovf.sticky", 32'(overflow), 32'd1);

        // Flush of a 5-bit partial word.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("flush.level", 32'(rd_water_level), 32'd1);
        check("flush.cnt", 32'(bit_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("flush2.level", 32'(rd_water_level), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("flush.word", rd_data, 32'h0000_000D);

        // Flush coinciding with completion: one push only.
        for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("flushdone.level", 32'(rd_water_level), 32'd1);

        // Simultaneous push and read at full.
        do_reset();
        for (int k = 0; k < 64; k++) send_word(32'hC000_0000 + 32'(k), 1'b0);
        send_word(32'hBEEF_0001, 1'b1);
        check("sim.level", 32'(rd_water_level), 32'd64);
        check("sim.ovf", 32'(overflow), 32'd0);
        check("sim.oldest", rd_data, 32'hC000_0000);
        for (int k = 0; k < 64; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sim.last", rd_data, 32'hBEEF_0001);

        // Reset mid-word.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b0);
        do_reset();
        send_word(32'hA5A5_A5A5, 1'b0);
        check("rstmid.level", 32'(rd_water_level), 32'd1);
        check("rstmid.cnt", 32'(bit_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rstmid.word", rd_data, 32'hA5A5_A5A5);

        // Empty read is ignored.
        held = rd_data;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("empty.rd_data", rd_data, held);
        check("empty.level", 32'(rd_water_level), 32'd0);
        check("empty.flag", 32'(rd_empty), 32'd1);

        // Randomized phases with varying read pressure.
        do_reset();
        for (int ph = 0; ph < 12; ph++) begin
            int rd_pct;
            rd_pct = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 50 : 95);
            for (int c = 0; c < 700; c++) begin
                step(1'($urandom_range(0, 99) < 85), 1'($urandom),
                     1'($urandom_range(0, 99) < 3),
                     1'($urandom_range(0, 99) < rd_pct));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
